// File: rtl/cordic_angle_gen_if.sv
// Request/status bundle between a sweep controller and the CORDIC angle generator.
// The controller drives the sweep request; the generator returns the angle stream and status.
interface cordic_angle_gen_if #(
    parameter int unsigned CNT_W = 16
);
    logic                    start;
    logic                    abort;
    logic signed [31:0]      start_angle;
    logic signed [31:0]      step;
    logic        [CNT_W-1:0] num_samples;
    logic signed [31:0]      angle;
    logic                    angle_vaild;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, abort, start_angle, step, num_samples,
        input  angle, angle_vaild, busy, done, err
    );

    modport slave (
        input  start, abort, start_angle, step, num_samples,
        output angle, angle_vaild, busy, done, err
    );
endinterface

// File: rtl/cordic_angle_gen.sv
// Generates a stream of Q16.16 degree angles start, start+step, ... wrapped to [-180, +180),
// one per cycle, to feed a CORDIC sin/cos stage.
module cordic_angle_gen #(
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    cordic_angle_gen_if.slave bus
);
    localparam logic signed [32:0] HalfTurn = 33'sd11796480;
    localparam logic signed [32:0] FullTurn = 33'sd23592960;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic signed [31:0] angle_q, angle_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vaild_q, vaild_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic signed [32:0] start_x;
    logic signed [32:0] step_x;
    logic               start_ok;

    // Operands are already in range, so one correction brings the sum back into range.
    function automatic logic signed [31:0] wrap_add(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s >= HalfTurn) begin
            s = s - FullTurn;
        end else if (s < -HalfTurn) begin
            s = s + FullTurn;
        end
        return s[31:0];
    endfunction

    assign start_x  = {bus.start_angle[31], bus.start_angle};
    assign step_x   = {bus.step[31], bus.step};
    assign start_ok = (start_x >= -HalfTurn) && (start_x < HalfTurn) &&
                      (step_x > -HalfTurn) && (step_x < HalfTurn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && start_ok) begin
                    state_d = (bus.num_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath; acc_q is the angle to emit next.
    always_comb begin
        angle_d = angle_q;
        acc_d   = acc_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        vaild_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (start_ok) begin
                        step_d = bus.step;
                        if (bus.num_samples == '0) begin
                            done_d = 1'b1;
                        end else begin
                            angle_d = bus.start_angle;
                            acc_d   = wrap_add(bus.start_angle, bus.step);
                            cnt_d   = bus.num_samples - CNT_W'(1);
                            vaild_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (!bus.abort) begin
                    if (cnt_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        angle_d = acc_q;
                        acc_d   = wrap_add(acc_q, step_q);
                        cnt_d   = cnt_q - CNT_W'(1);
                        vaild_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            angle_q <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            vaild_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            angle_q <= angle_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            vaild_q <= vaild_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.angle       = angle_q;
    assign bus.angle_vaild = vaild_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule
